pwm_dac_multi: RTL and testbench

PWM_DAC_MULTI -- requirements
Module: pwm_dac_multi

---
 rtl/pwm_dac_multi.sv | 125 ++++++++++++
 tb/tb_pwm_dac_multi.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac_multi.sv
// ---------------------------------------------------------------------------
// pwm_dac_multi
//   Multi-channel PWM DAC. A shared prescaler produces a tick every PRESCALE
//   enabled clocks; a shared phase counter advances once per tick. When the
//   phase counter wraps to 0 (the period boundary) every channel's duty code
//   is captured at once, so all channels switch duty on the same edge.
//
//   Default build: left-aligned pulses, phase counter WIDTH bits wide,
//   output high while phase < duty.
//   Build option PWM_DAC_CENTER_EN: phase counter WIDTH+1 bits wide,
//   output high while (2^WIDTH - duty) <= phase < (2^WIDTH + duty), i.e. a
//   2*duty-tick pulse centred in the period.
//
// Parameters
//   WIDTH     duty resolution per channel in bits (2..12)
//   CHANNELS  number of PWM outputs (1..8)
//   PRESCALE  system clocks per PWM tick (1..4096)
//
// Ports
//   Clk          system clock, rising edge
//   Reset_n      asynchronous active-low reset
//   Enable       1 = run; 0 freezes prescaler, phase, duty and outputs
//   DACin        duty codes, channel i at [i*WIDTH +: WIDTH]
//   DACout       registered PWM outputs, one bit per channel
//   PeriodStart  registered one-clock pulse after each period boundary
// ---------------------------------------------------------------------------
module pwm_dac_multi #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int PRESCALE = 512
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      Enable,
    input  logic [CHANNELS*WIDTH-1:0] DACin,
    output logic [CHANNELS-1:0]       DACout,
    output logic                      PeriodStart
);

`ifdef PWM_DAC_CENTER_EN
    localparam int PHASE_W = WIDTH + 1;
    // Midpoint of the doubled period; pulses are placed symmetrically around it.
    localparam logic [WIDTH:0] CENTER = {1'b1, {WIDTH{1'b0}}};
`else
    localparam int PHASE_W = WIDTH;
`endif

    // A prescaler of 1 still needs a one-bit register that simply stays at 0.
    localparam int              PS_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_RELOAD = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0]                r_presc;
    logic [PHASE_W-1:0]             r_phase;
    logic [CHANNELS-1:0][WIDTH-1:0] r_duty;
    logic [CHANNELS-1:0]            r_dacout;
    logic                           r_period_start;

    logic                           w_tick;
    logic                           w_wrap;
    logic [PHASE_W-1:0]             w_phase_next;
    logic [CHANNELS-1:0][WIDTH-1:0] w_duty_next;
    logic [CHANNELS-1:0]            w_pwm_next;

    assign w_tick       = Enable && (r_presc == '0);
    assign w_phase_next = r_phase + 1'b1;
    assign w_wrap       = (w_phase_next == '0);

    // Output level for the phase being entered. On the boundary edge the
    // freshly captured code is used, so the new duty takes effect at phase 0.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // so no path leaves a signal unassigned and no latch is inferred.
        w_duty_next = r_duty;
        w_pwm_next  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (w_wrap) begin
                w_duty_next[c] = DACin[c*WIDTH +: WIDTH];
            end
`ifdef PWM_DAC_CENTER_EN
            w_pwm_next[c] = (w_phase_next >= (CENTER - {1'b0, w_duty_next[c]})) &&
                            (w_phase_next <  (CENTER + {1'b0, w_duty_next[c]}));
`else
            w_pwm_next[c] = (w_phase_next < w_duty_next[c]);
`endif
        end
    end

    // Prescaler: counts PRESCALE-1 down to 0; reset leaves it at 0 so the
    // first enabled clock after reset is already a tick.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            // NOTE: state registers use non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            r_presc <= '0;
        end else if (Enable) begin
            if (r_presc == '0) begin
                r_presc <= PS_RELOAD;
            end else begin
                r_presc <= r_presc - 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_phase        <= '0;
            // NOTE: the duty bank is a handful of flops, not a RAM, and must
            // read 0 after reset so outputs stay low until the first boundary.
            r_duty         <= '0;
            r_dacout       <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_tick && w_wrap;
            if (w_tick) begin
                r_phase  <= w_phase_next;
                r_duty   <= w_duty_next;
                r_dacout <= w_pwm_next;
            end
        end
    end

    assign DACout      = r_dacout;
    assign PeriodStart = r_period_start;

endmodule

// File: tb/tb_pwm_dac_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_dac_multi
//   Two instances share all inputs: dut_a with PRESCALE=4, dut_b with
//   PRESCALE=1. A tick-counting reference model predicts both every clock;
//   directed sequences cover duty tables, mid-period input changes, Enable
//   freeze, async reset and (when PWM_DAC_CENTER_EN is defined) centring.
// ---------------------------------------------------------------------------
module tb_pwm_dac_multi;
    localparam int W  = 4;
    localparam int CH = 2;
`ifdef PWM_DAC_CENTER_EN
    localparam int P = W + 1;
`else
    localparam int P = W;
`endif
    localparam int NPH   = 1 << P;
    localparam int PSC_A = 4;
    localparam int PSC_B = 1;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b1;
    logic [CH*W-1:0] dacin = '0;
    logic [CH-1:0]   out_a, out_b;
    logic            ps_a, ps_b;

    always #5 clk = ~clk;

    pwm_dac_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(PSC_A)) dut_a (
        .Clk(clk), .Reset_n(rst_n), .Enable(en), .DACin(dacin),
        .DACout(out_a), .PeriodStart(ps_a)
    );

    pwm_dac_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(PSC_B)) dut_b (
        .Clk(clk), .Reset_n(rst_n), .Enable(en), .DACin(dacin),
        .DACout(out_b), .PeriodStart(ps_b)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // High ticks per period for a code, from the pulse-shape rules.
    function automatic int exp_high(input int code);
`ifdef PWM_DAC_CENTER_EN
        return 2 * code;
`else
        return code;
`endif
    endfunction

    function automatic logic pwm_level(input int ph, input int d);
`ifdef PWM_DAC_CENTER_EN
        return (ph >= (1 << W) - d) && (ph < (1 << W) + d);
`else
        return ph < d;
`endif
    endfunction

    // ---------------- reference model ----------------
    // Counts enabled clocks and ticks since reset; phase and period follow
    // from plain division, duty codes are captured when phase returns to 0.
    int            m_en    [2];
    int            m_ticks [2];
    int            m_duty  [2][CH];
    logic [CH-1:0] m_out   [2];
    logic          m_ps    [2];

    task automatic model_step(input int j, input int psc);
        int ph;
        if (!rst_n) begin
            m_en[j] = 0; m_ticks[j] = 0; m_out[j] = '0; m_ps[j] = 1'b0;
            for (int c = 0; c < CH; c++) m_duty[j][c] = 0;
        end else if (en) begin
            m_ps[j] = 1'b0;
            if (m_en[j] % psc == 0) begin
                m_ticks[j]++;
                ph = m_ticks[j] % NPH;
                if (ph == 0) begin
                    m_ps[j] = 1'b1;
                    for (int c = 0; c < CH; c++)
                        m_duty[j][c] = int'(dacin >> (c * W)) & ((1 << W) - 1);
                end
                for (int c = 0; c < CH; c++) m_out[j][c] = pwm_level(ph, m_duty[j][c]);
            end
            m_en[j]++;
        end else begin
            m_ps[j] = 1'b0;
        end
    endtask

    always begin
        @(posedge clk);
        model_step(0, PSC_A);
        model_step(1, PSC_B);
        #1;
        check("mon_out_a", out_a, m_out[0]);
        check("mon_ps_a",  ps_a,  m_ps[0]);
        check("mon_out_b", out_b, m_out[1]);
        check("mon_ps_b",  ps_b,  m_ps[1]);
    end

    // ---------------- helpers ----------------
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Advance at least one clock, then until PeriodStart of the chosen DUT.
    task automatic wait_ps(input int sel, input string name, output int k);
        int budget;
        budget = 4 * NPH * ((sel != 0) ? PSC_B : PSC_A);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (((sel != 0) ? ps_b : ps_a) !== 1'b1 && k < budget);
        check(name, (sel != 0) ? ps_b : ps_a, 1);
    endtask

    // Sample n clocks starting with the current one; count highs and pulses.
    task automatic measure(input int sel, input int n, output int h0, output int h1, output int nps);
        h0 = 0; h1 = 0; nps = 0;
        for (int i = 0; i < n; i++) begin
            h0  += int'((sel != 0) ? out_b[0] : out_a[0]);
            h1  += int'((sel != 0) ? out_b[1] : out_a[1]);
            nps += int'((sel != 0) ? ps_b : ps_a);
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [CH*W-1:0] din;
        int              exp0;
        int              exp1;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int k, h0, h1, nps, a0, a1, ap;
        logic [CH-1:0] held;

        tbl[0] = '{8'hF0, 0, 15};
        tbl[1] = '{8'h5A, 10, 5};
        tbl[2] = '{8'h18, 8, 1};
        tbl[3] = '{8'h00, 0, 0};
        tbl[4] = '{8'hFF, 15, 15};
        tbl[5] = '{8'h7E, 14, 7};

        // Reset state.
        rst_n = 1'b0; en = 1'b1; dacin = 8'h3A;
        step(3);
        check("rst_out_a", out_a, 0);
        check("rst_out_b", out_b, 0);
        check("rst_ps_a",  ps_a,  0);
        check("rst_ps_b",  ps_b,  0);
        rst_n = 1'b1;

        // PRESCALE=4, codes A (ch0) and 3 (ch1): first boundary after NPH ticks.
        wait_ps(0, "a_first_ps", k);
        check("a_first_ps_delay", k, 1 + (NPH - 1) * PSC_A);
`ifndef PWM_DAC_CENTER_EN
        check("a_rise_on_boundary", out_a, 2'b11);
`endif
        measure(0, NPH * PSC_A, h0, h1, nps);
        check("a_high_ch0", h0, exp_high(10) * PSC_A);
        check("a_high_ch1", h1, exp_high(3) * PSC_A);
        check("a_ps_count", nps, 1);

        // Duty table on the PRESCALE=1 instance.
        for (int i = 0; i < 6; i++) begin
            dacin = tbl[i].din;
            wait_ps(1, "tbl_wait", k);
            measure(1, NPH, h0, h1, nps);
            check($sformatf("tbl%0d_ch0", i), h0, exp_high(tbl[i].exp0));
            check($sformatf("tbl%0d_ch1", i), h1, exp_high(tbl[i].exp1));
            check($sformatf("tbl%0d_ps", i), nps, 1);
        end

        // Mid-period change 2 -> C takes effect only at the next boundary.
        dacin = 8'h02;
        wait_ps(1, "mid_wait", k);
        measure(1, 5, a0, a1, ap);
        dacin = 8'h0C;
        measure(1, NPH - 5, h0, h1, nps);
        check("mid_cur_high", a0 + h0, exp_high(2));
        check("mid_cur_ps", ap + nps, 1);
        measure(1, NPH, h0, h1, nps);
        check("mid_next_high", h0, exp_high(12));
        check("mid_next_ps", nps, 1);

        // Enable low for 37 clocks mid-period.
        dacin = 8'h09;
        wait_ps(1, "en_wait", k);
        measure(1, 4, a0, a1, ap);
        en   = 1'b0;
        held = out_b;
        for (int i = 0; i < 37; i++) begin
            step(1);
            check("en_hold_out", out_b, held);
            check("en_hold_ps", ps_b, 0);
        end
        en = 1'b1;
        measure(1, NPH - 4, h0, h1, nps);
        check("en_total_high", a0 + h0, exp_high(9));
        check("en_period_end_ps", ps_b, 1);

        // Asynchronous reset mid-period.
        dacin = 8'hFF;
        wait_ps(1, "rst_wait", k);
        measure(1, 3, h0, h1, nps);
        check("pre_rst_out_b", out_b, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        check("async_out_a", out_a, 0);
        check("async_out_b", out_b, 0);
        check("async_ps_a", ps_a, 0);
        check("async_ps_b", ps_b, 0);
        step(3);
        rst_n = 1'b1;
        wait_ps(0, "post_rst_ps", k);
        check("post_rst_delay", k, 1 + (NPH - 1) * PSC_A);

`ifdef PWM_DAC_CENTER_EN
        // Code 5 centred: high on phases 11..20 of each 32-tick period.
        dacin = 8'h05;
        wait_ps(1, "ctr_wait", k);
        wait_ps(1, "ctr_wait2", k);
        for (int ph = 0; ph < 32; ph++) begin
            check($sformatf("ctr_ph%0d", ph), out_b[0], (ph >= 11 && ph <= 20) ? 1 : 0);
            step(1);
        end
`endif

        // Randomized traffic checked by the model every clock.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if ($urandom_range(7) == 0) dacin = CH'(0) | (CH*W)'($urandom);
            en    = ($urandom_range(5) != 0);
            rst_n = ($urandom_range(149) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b1;
        step(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
